// File: rtl/mips_pkg.sv
// Shared pipeline constants: control-word bit positions and well-known encodings.
package mips_pkg;
    localparam int         CTRL_MEM_READ  = 3;
    localparam int         CTRL_REG_WRITE = 2;
    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam logic [7:0] CTRL_NOP       = 8'd0;
endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detection and the ID stall request. Purely combinational.
module id_ex_hazard #(
    parameter int AW = 5
) (
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] ex_wreg,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          mem_stall,
    input  logic          flush,
    output logic          load_use,
    output logic          stall_id
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_uses_rs && (id_rs == ex_wreg);
    assign rt_hit   = id_uses_rt && (id_rt == ex_wreg);
    assign load_use = ex_valid && ex_mem_read && (ex_wreg != '0) && id_valid && (rs_hit || rt_hit);

    // Held low in reset so the front end never sees a stall from a pipe that is being cleared.
    assign stall_id = rst_n && !flush && (mem_stall || load_use);
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubbles, mispredict flush, stalled-operand
// refresh from write-back and saturating bubble/flush counters.
module id_ex_pipe
    import mips_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [AW-1:0]     id_wreg,
    input  logic [DW-1:0]     id_rdata1,
    input  logic [DW-1:0]     id_rdata2,
    input  logic [DW-1:0]     id_imm,
    input  logic [DW-1:0]     id_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [AW-1:0]     wb_wreg,
    input  logic [DW-1:0]     wb_wdata,
    output logic              ex_valid,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_wreg,
    output logic [DW-1:0]     ex_rdata1,
    output logic [DW-1:0]     ex_rdata2,
    output logic [DW-1:0]     ex_imm,
    output logic [DW-1:0]     ex_pc4,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic load_use;
    logic wb_live;
    logic bubble_inc;
    logic flush_inc;

    id_ex_hazard #(.AW(AW)) u_hazard (
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
        .ex_wreg     (ex_wreg),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .mem_stall   (mem_stall),
        .flush       (flush),
        .load_use    (load_use),
        .stall_id    (stall_id)
    );

    assign wb_live    = wb_reg_write && (wb_wreg != '0) && ex_valid;
    assign bubble_inc = !flush && !mem_stall && load_use;
    assign flush_inc  = flush && (ex_valid || id_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_wreg   <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc4    <= '0;
            ex_ctrl   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (mem_stall) begin
            // The reg-file bypass only covered the ID read, so a held instruction
            // would otherwise keep operands that write-back has since overwritten.
            if (wb_live && (wb_wreg == ex_rs)) ex_rdata1 <= wb_wdata;
            if (wb_live && (wb_wreg == ex_rt)) ex_rdata2 <= wb_wdata;
        end else if (load_use) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid  <= id_valid;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_wreg   <= id_wreg;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc4    <= id_pc4;
            ex_ctrl   <= id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bubble_inc && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1))   flush_cnt  <= flush_cnt + 1'b1;
        end
    end
endmodule
